// File: rtl/mips_defs_pkg.sv
// mips_defs_pkg
//   Definitions shared between the EX-stage decode and the iterative divider:
//   the divider state encoding, the zero word, the DIV/DIVU function codes and
//   the operand width used for the divider.
package mips_defs_pkg;

   localparam int          DIV_WIDTH  = 32;
   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

   // SPECIAL-opcode function fields decoded by EX to select the divider
   localparam logic [5:0]  DIV_OP_DIV  = 6'b01_1010;
   localparam logic [5:0]  DIV_OP_DIVU = 6'b01_1011;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

endpackage : mips_defs_pkg

// File: rtl/div_unit_if.sv
// div_unit_if
//   Request/response bundle between the EX stage (master) and the divider
//   (slave).
//   signed_div_i : 1 = DIV (two's complement), 0 = DIVU
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held high by EX until it has consumed ready_o
//   annul_i      : cancel an in-flight divide
//   result_o     : {remainder, quotient}
//   ready_o      : result_o valid
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic                   signed_div_i;
   logic [WIDTH-1:0]       opdata1_i;
   logic [WIDTH-1:0]       opdata2_i;
   logic                   start_i;
   logic                   annul_i;
   logic [2*WIDTH-1:0]     result_o;
   logic                   ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );

endinterface : div_unit_if

// File: rtl/div_unit_step.sv
// div_unit_step
//   One radix-2 restoring iteration, purely combinational.
//   partial_rem   : running remainder (always < divisor)
//   dividend      : remaining dividend bits in the upper part, quotient bits
//                   accumulating in the lower part
//   divisor       : divisor magnitude (non-zero)
//   next_rem      : remainder after this step
//   next_dividend : dividend shifted left with the new quotient bit at bit 0
module div_unit_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] partial_rem,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] next_rem,
   output logic [WIDTH-1:0] next_dividend
);

   // The shifted remainder can reach 2*divisor-1, so it needs one extra bit,
   // and the trial difference one more for the borrow.
   logic [WIDTH:0]   shifted_s;
   logic [WIDTH+1:0] diff_s;

   // Trial subtract: keep the difference when it does not borrow
   always_comb begin
      shifted_s     = {partial_rem, dividend[WIDTH-1]};
      diff_s        = {1'b0, shifted_s} - {2'b00, divisor};
      next_rem      = shifted_s[WIDTH-1:0];
      next_dividend = {dividend[WIDTH-2:0], 1'b0};
      if (diff_s[WIDTH+1] == 1'b0) begin
         next_rem      = diff_s[WIDTH-1:0];
         next_dividend = {dividend[WIDTH-2:0], 1'b1};
      end else begin
         next_rem      = shifted_s[WIDTH-1:0];
         next_dividend = {dividend[WIDTH-2:0], 1'b0};
      end
   end

endmodule : div_unit_step

// File: rtl/div_unit.sv
// div_unit
//   Multi-cycle radix-2 restoring divider for DIV/DIVU. A request sampled in
//   FREE produces ready_o WIDTH edges later (one edge later for a zero
//   divisor); the result is held while start_i stays high.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, dominates all other inputs
//   bus : div_unit_if slave port (operands, start/annul, result/ready)
module div_unit
   import mips_defs_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   div_unit_if.slave    bus
);

   localparam int CNT_W = $clog2(WIDTH);

   div_state_e          state_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [WIDTH-1:0]    rem_r;
   logic [WIDTH-1:0]    dvd_r;
   logic [WIDTH-1:0]    divisor_r;
   logic                neg_quot_r;
   logic                neg_rem_r;
   logic [2*WIDTH-1:0]  result_r;
   logic                ready_r;

   logic [WIDTH-1:0]    op1_mag_s;
   logic [WIDTH-1:0]    op2_mag_s;
   logic [WIDTH-1:0]    next_rem_s;
   logic [WIDTH-1:0]    next_dvd_s;
   logic [WIDTH-1:0]    quot_fix_s;
   logic [WIDTH-1:0]    rem_fix_s;

   function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   div_unit_step #(.WIDTH(WIDTH)) u_step (
      .partial_rem   (rem_r),
      .dividend      (dvd_r),
      .divisor       (divisor_r),
      .next_rem      (next_rem_s),
      .next_dividend (next_dvd_s)
   );

   // Operand magnitudes at sampling and sign correction of the final step.
   // The most negative value maps onto itself, which is its correct unsigned
   // magnitude, so -2^(W-1)/-1 wraps to q=-2^(W-1), r=0.
   always_comb begin
      op1_mag_s  = bus.opdata1_i;
      op2_mag_s  = bus.opdata2_i;
      quot_fix_s = next_dvd_s;
      rem_fix_s  = next_rem_s;
      if (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) begin
         op1_mag_s = twos_neg(bus.opdata1_i);
      end else begin
         op1_mag_s = bus.opdata1_i;
      end
      if (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) begin
         op2_mag_s = twos_neg(bus.opdata2_i);
      end else begin
         op2_mag_s = bus.opdata2_i;
      end
      if (neg_quot_r) begin
         quot_fix_s = twos_neg(next_dvd_s);
      end else begin
         quot_fix_s = next_dvd_s;
      end
      if (neg_rem_r) begin
         rem_fix_s = twos_neg(next_rem_s);
      end else begin
         rem_fix_s = next_rem_s;
      end
   end

   // Divider FSM, iteration counter and registered result/ready
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= DIV_FREE;
         cnt_r      <= '0;
         rem_r      <= '0;
         dvd_r      <= '0;
         divisor_r  <= '0;
         neg_quot_r <= 1'b0;
         neg_rem_r  <= 1'b0;
         result_r   <= '0;
         ready_r    <= 1'b0;
      end else begin
         case (state_r)
            DIV_FREE: begin
               result_r <= '0;
               ready_r  <= 1'b0;
               if (bus.start_i && !bus.annul_i) begin
                  dvd_r      <= op1_mag_s;
                  divisor_r  <= op2_mag_s;
                  rem_r      <= '0;
                  cnt_r      <= '0;
                  neg_quot_r <= bus.signed_div_i &
                                (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                  neg_rem_r  <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
                  if (bus.opdata2_i == '0) begin
                     state_r <= DIV_BYZERO;
                  end else begin
                     state_r <= DIV_ON;
                  end
               end else begin
                  state_r <= DIV_FREE;
               end
            end
            DIV_BYZERO: begin
               state_r  <= DIV_END;
               result_r <= '0;
               ready_r  <= 1'b1;
            end
            DIV_ON: begin
               if (bus.annul_i) begin
                  state_r  <= DIV_FREE;
                  result_r <= '0;
                  ready_r  <= 1'b0;
               end else begin
                  rem_r <= next_rem_s;
                  dvd_r <= next_dvd_s;
                  cnt_r <= cnt_r + CNT_W'(1);
                  if (cnt_r == CNT_W'(WIDTH - 1)) begin
                     state_r  <= DIV_END;
                     result_r <= {rem_fix_s, quot_fix_s};
                     ready_r  <= 1'b1;
                  end else begin
                     state_r  <= DIV_ON;
                     ready_r  <= 1'b0;
                  end
               end
            end
            DIV_END: begin
               // annul_i is ignored here: the result is already handed to EX
               if (!bus.start_i) begin
                  state_r  <= DIV_FREE;
                  result_r <= '0;
                  ready_r  <= 1'b0;
               end else begin
                  state_r  <= DIV_END;
               end
            end
            default: begin
               state_r  <= DIV_FREE;
               result_r <= '0;
               ready_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.result_o = result_r;
   assign bus.ready_o  = ready_r;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// tb_div_unit
//   Directed bench for div_unit: expected results are pushed to a scoreboard
//   queue when a request is driven and popped when ready_o rises.
module tb_div_unit;
   import mips_defs_pkg::*;

   localparam int W = 32;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [2*W-1:0] sb[$];

   div_unit_if #(.WIDTH(W)) bus ();

   div_unit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [2*W-1:0] obs,
                        input logic [2*W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: divide magnitudes with native operators, then fix signs
   function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic [W-1:0] ma, mb, q, r;
      if (b == 32'd0) return 64'd0;
      ma = (sgn && a[W-1]) ? (32'd0 - a) : a;
      mb = (sgn && b[W-1]) ? (32'd0 - b) : b;
      q  = ma / mb;
      r  = ma % mb;
      if (sgn && (a[W-1] ^ b[W-1])) q = 32'd0 - q;
      if (sgn && a[W-1])            r = 32'd0 - r;
      return {r, q};
   endfunction

   // Latency counts edges from the sampling edge up to the one raising ready_o
   task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp,
                          input int exp_lat, input logic annul_in_end);
      logic [2*W-1:0] want;
      int n;
      sb.push_back(exp);
      @(negedge clk);
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      n = 0;
      while (n < 100 && bus.ready_o !== 1'b1) begin
         @(negedge clk);
         n++;
         bus.opdata1_i = $urandom;
         bus.opdata2_i = $urandom;
      end
      check({tag, ".ready"}, 64'(bus.ready_o), 64'd1);
      check({tag, ".latency"}, 64'(n), 64'(exp_lat));
      if (sb.size() > 0) begin
         want = sb.pop_front();
      end else begin
         want = 64'd0;
      end
      check({tag, ".result"}, bus.result_o, want);
      bus.annul_i = annul_in_end;
      @(negedge clk);
      check({tag, ".hold_ready"}, 64'(bus.ready_o), 64'd1);
      check({tag, ".hold_result"}, bus.result_o, want);
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      @(negedge clk);
      check({tag, ".drop_ready"}, 64'(bus.ready_o), 64'd0);
      check({tag, ".drop_result"}, bus.result_o, 64'd0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd0;
      bus.opdata2_i    = 32'd0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      repeat (3) @(negedge clk);
      check("reset.ready", 64'(bus.ready_o), 64'd0);
      check("reset.result", bus.result_o, 64'd0);
      rst = 1'b0;

      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, W + 1, 1'b0);
      run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, W + 1, 1'b0);
      run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, W + 1, 1'b1);
      run_div("divu_by0", 1'b0, 32'd1234, 32'd0, 64'd0, 2, 1'b0);
      run_div("div_by0", 1'b1, 32'hFFFF_0000, 32'd0, 64'd0, 2, 1'b0);
      run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, W + 1, 1'b0);
      run_div("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, W + 1, 1'b0);

      // start with annul held is ignored in FREE
      @(negedge clk);
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd50;
      bus.opdata2_i    = 32'd5;
      bus.start_i      = 1'b1;
      bus.annul_i      = 1'b1;
      repeat (40) @(negedge clk);
      check("annul_free.ready", 64'(bus.ready_o), 64'd0);
      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;

      // annul at count=10 (after the 11th edge including the sampling one)
      @(negedge clk);
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd1000;
      bus.opdata2_i    = 32'd3;
      bus.start_i      = 1'b1;
      repeat (11) @(negedge clk);
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      @(negedge clk);
      bus.annul_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         check("annul_on.no_ready", 64'(bus.ready_o), 64'd0);
         @(negedge clk);
      end
      run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, W + 1, 1'b0);

      // reset in the middle of ON
      @(negedge clk);
      bus.signed_div_i = 1'b1;
      bus.opdata1_i    = 32'd100;
      bus.opdata2_i    = 32'd7;
      bus.start_i      = 1'b1;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_on.ready", 64'(bus.ready_o), 64'd0);
      check("rst_on.result", bus.result_o, 64'd0);
      bus.start_i = 1'b0;
      rst = 1'b0;

      // reset while a result is held in END
      @(negedge clk);
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd77;
      bus.opdata2_i    = 32'd10;
      bus.start_i      = 1'b1;
      repeat (W + 2) @(negedge clk);
      check("rst_end.pre_result", bus.result_o, {32'd7, 32'd7});
      rst = 1'b1;
      @(negedge clk);
      check("rst_end.ready", 64'(bus.ready_o), 64'd0);
      check("rst_end.result", bus.result_o, 64'd0);
      bus.start_i = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = (i == 3) ? 32'd1 : ($urandom >> (i * 5));
         run_div("rand", i[0], ra, rb, model(i[0], ra, rb), (rb == 32'd0) ? 2 : W + 1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_div_unit
